// File: rtl/au_prefix_or_dec.sv
// au_prefix_or_dec: two-stage decoder for prefix-OR (thermometer) masks.
// S1 captures the mask and its shape check; S2 captures the index, one-hot,
// zero and error results. A saturating counter tallies malformed masks that
// are actually delivered to the sink.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer must hold valid and data stable until ready is seen. Here
// in_ready depends combinationally only on out_ready and internal state, and
// out_valid/results come straight from registers.
module au_prefix_or_dec #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  idx,
  output logic [WIDTH-1:0] onehot,
  output logic             zero,
  output logic             err,
  output logic [CNTW-1:0]  err_cnt,
  input  logic             err_clr
);

  logic             s1_v;
  logic             s2_v;
  logic [WIDTH-1:0] s1_pm;
  logic             s1_bad;
  logic             s1_adv;
  logic             s2_adv;
  logic             bad_c;
  logic [WIDTH-1:0] onehot_c;
  logic [IDXW-1:0]  idx_c;
  logic             zero_c;

  // A stage may take new contents when it is empty or its successor moves on.
  assign s2_adv   = ~s2_v | out_ready;
  assign s1_adv   = ~s1_v | s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_v;

  // Shape check: a one sitting directly above a zero breaks the thermometer.
  assign bad_c = |(pm[WIDTH-1:1] & ~pm[WIDTH-2:0]);

  // Stage 1 register: mask plus its malformed flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_pm  <= '0;
      s1_bad <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_pm  <= pm;
        s1_bad <= bad_c;
      end
    end
  end

  // Leading-one decode of the stage-1 mask; the highest set bit wins.
  always_comb begin
    onehot_c = s1_pm & ~(s1_pm >> 1);
    zero_c   = ~|s1_pm;
    idx_c    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_pm[i]) idx_c = IDXW'(i);
    end
  end

  // Stage 2 register: results only change when a real mask moves in, so a
  // stalled or idle output keeps its last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      idx    <= '0;
      onehot <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        idx    <= idx_c;
        onehot <= onehot_c;
        zero   <= zero_c;
        err    <= s1_bad;
      end
    end
  end

  // Saturating count of delivered malformed masks; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (s2_v && out_ready && err && (err_cnt != {CNTW{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/au_prefix_or_dec.md
# au_prefix_or_dec

Pipelined decoder for prefix-OR masks. It is the receiving end of the prefix-OR datapath: it accepts a mask `pm`, where `pm[i] = |x[WIDTH-1:i]` for some source word x, and returns the position of the leading one of x as an index and a one-hot vector. It also checks the mask's shape and keeps a saturating count of malformed masks. It sits after the prefix-OR stage in leading-zero and normalization paths and uses a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 8: mask width, ≥ 2.
- `IDXW`, default `$clog2(WIDTH)`: index width. It is derived and must not be overridden.
- `CNTW`, default 8: width of the error counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  `pm` is valid.
- `in_ready`  out  1  block can accept a mask this cycle.
- `pm`  in  WIDTH  prefix-OR mask.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  sink accepts the result.
- `idx`  out  IDXW  index of the leading one.
- `onehot`  out  WIDTH  one-hot leading-one vector.
- `zero`  out  1  mask is all zero.
- `err`  out  1  mask is malformed.
- `err_cnt`  out  CNTW  saturating count of malformed masks delivered.
- `err_clr`  in  1  synchronous clear of `err_cnt`.

## Operation
- Well-formed mask: thermometer shape, ones at the bottom (`0…01…1`), including all-zero.
- Malformed mask: any i ≥ 1 with `pm[i]=1` and `pm[i-1]=0`.
- Stage 1 (S1) registers `pm` and computes `bad = |(pm[WIDTH-1:1] & ~pm[WIDTH-2:0])`.
- Stage 2 (S2) registers the results:
  - `onehot = pm & ~(pm >> 1)`, i.e. bit i is set when `pm[i]=1` and `pm[i+1]=0`, with `pm[WIDTH]` taken as 0.
  - `idx` = position of the highest set bit of `pm`; 0 when `pm` is zero.
  - `zero = ~|pm`.
  - `err = bad`.
- Malformed masks:
  - `onehot` and `idx` are still computed from the highest set bit. `onehot` is the raw formula above and may carry several bits.
  - Downstream must ignore `onehot` and `idx` when `err=1`.
  - For `pm = 0`: `zero=1`, `idx=0`, `onehot=0`, `err=0`.
- Pipeline control (each stage has a valid flag `s1_v` / `s2_v`):
  - `s2_adv = ~s2_v | out_ready`
  - `s1_adv = ~s1_v | s2_adv`
  - `in_ready = s1_adv`. It is combinational from `out_ready`, with no input-to-output combinational path otherwise.
  - S1 loads when `in_valid & in_ready`. `s1_v` is set if `in_valid`, cleared otherwise, whenever `s1_adv`.
  - S2 loads S1 contents when `s2_adv`. `s2_v <= s1_v`.
- Stalling: while stalled (`s2_v & ~out_ready`), all `out_*` result fields hold stable. `in_ready` drops once both stages are full.
- Error counter:
  - `err_cnt` increments by 1 on each output handshake (`out_valid & out_ready`) with `err=1`.
  - It saturates at `2^CNTW-1` and does not wrap.
  - `err_clr` clears it to 0 and takes priority over an increment in the same cycle.
- No bubbles: with `in_valid` and `out_ready` held high, one result is delivered per cycle.

## Timing
- Latency: a mask accepted at rising edge t shows `out_valid=1` with its results after edge t+1. This holds when `out_ready` stays high.
- Throughput: 1 per cycle.
- Buffering: up to 2 masks are held internally.
- Reset (async assert, synchronous-style deassert expected upstream):
  - `s1_v = s2_v = 0`, so `out_valid = 0`.
  - `in_ready = 1` combinationally once reset is released.
  - `idx = 0`, `onehot = 0`, `zero = 0`, `err = 0`, `err_cnt = 0`.
- Reset in mid-stream: contents of both stages are discarded, and no partial output is produced after release.
- Simultaneous events:
  - A new input and an output handshake in the same cycle on a full pipe: the input is accepted, S1 shifts to S2, and no data is lost or duplicated.
  - `err_clr` together with an error handshake: `err_cnt` becomes 0.
- Output changes only on rising `clk` edges (or on reset).

## Test plan
- Exhaustive, WIDTH=8:
  - Drive every 8-bit `pm` with `out_ready=1`.
  - Compare against a behavioural model.
  - `pm=8'h0F` gives `idx=3`, `onehot=8'h08`, `zero=0`, `err=0`.
  - `pm=8'hFF` gives `idx=7`, `onehot=8'h80`.
  - `pm=0` gives `zero=1`, `idx=0`.
- Malformed masks:
  - `pm=8'h05` gives `err=1`, `idx=2`.
  - `pm=8'h80` gives `err=1`, `idx=7`.
  - After 3 malformed handshakes, `err_cnt=3`.
- Backpressure:
  - Hold `out_ready=0` and stream 3 masks.
  - The first 2 are accepted, then `in_ready=0`.
  - Raise `out_ready`: results come out in order with no loss or duplication, and outputs are stable while stalled.
- Saturation, CNTW=2:
  - Send 5 malformed masks: `err_cnt` stays at 3.
  - Assert `err_clr` in the same cycle as an error handshake: `err_cnt=0`.
- Reset in mid-stream:
  - Assert `rst_n=0` with both stages full.
  - `out_valid` goes low immediately and `err_cnt=0`.
  - After release, the first output is the first mask accepted after reset.
- Random, WIDTH=32:
  - 10000 masks, half well-formed, with random `in_valid`/`out_ready`.
  - Scoreboard checks order, values and `err_cnt`.
